serial_adder_ctrl: RTL and testbench

- Bit-serial sequencer that time-shares one external 1-bit full_adder cell to add two WIDTH-bit operands.
- Holds the operand and sum shift registers and the carry flip-flop, and steps the adder one bit per clock from LSB to MSB.
- Sits between a requester (start/done handshake) and the combinational full_adder; the adder is instantiated outside this block.

---
 rtl/serial_adder_ctrl.sv | 113 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: steps an external 1-bit full adder LSB-first over two WIDTH-bit operands.
// Holds the operand/sum shift registers and the carry flop; the adder cell lives outside this block.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_z,
    input  logic             fa_s,
    input  logic             fa_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    // State and datapath registers; reset clears everything, including the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    // Next-state and datapath update; the final RUN step also latches the result copy.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sh_d = WIDTH'({fa_s, sum_sh_q} >> 1);
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_c;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    sum_d   = sum_sh_d;
                    cout_d  = fa_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status and adder-cell drive decode straight from registers, so reset clears them at once.
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign fa_x = (state_q == RUN) & a_sh_q[0];
    assign fa_y = (state_q == RUN) & b_sh_q[0];
    assign fa_z = (state_q == RUN) & carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl with a behavioural full-adder cell on the fa_* loop.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;
    logic             fa_x, fa_y, fa_z, fa_s, fa_c;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .fa_x (fa_x),
        .fa_y (fa_y),
        .fa_z (fa_z),
        .fa_s (fa_s),
        .fa_c (fa_c)
    );

    // External full-adder cell
    assign fa_s = fa_x ^ fa_y ^ fa_z;
    assign fa_c = (fa_x & fa_y) | (fa_x & fa_z) | (fa_y & fa_z);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pops one expectation per done pulse; checks result and the cycle it arrived in.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum",       32'(sum),  32'(e.sum));
                    chk("cout",      32'(cout), 32'(e.cout));
                    chk("done_cyc",  32'(cyc),  32'(e.cyc));
                end
            end
        end
    endtask

    // Pulse start for one edge and queue the hand-computed result; operands are then scrambled.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                         input logic [WIDTH-1:0] es, input logic ec);
        exp_t e;
        a = av; b = bv; cin = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e.sum = es; e.cout = ec; e.cyc = cyc + int'(WIDTH);
        sb.push_back(e);
        a = ~av; b = ~bv; cin = ~cv;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        exp_t e;
        int   n;
        fork
            monitor();
        join_none

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_fa",   32'({fa_x, fa_y, fa_z}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 0x5A + 0x3C; fa_x must walk A LSB-first
        issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        pat = 8'h5A;
        for (int i = 0; i < int'(WIDTH); i++) begin
            chk($sformatf("fa_x_bit%0d", i), 32'(fa_x), 32'(pat[i]));
            @(posedge clk); #1;
        end
        wait_idle();

        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        wait_idle();
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        wait_idle();

        // Carry-in only: carry seen by the cell in bit 0 and never again
        issue(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < int'(WIDTH); i++) begin
            chk($sformatf("fa_z_bit%0d", i), 32'(fa_z), (i == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        wait_idle();

        // Start during RUN cycle 3 is dropped
        issue(8'h21, 8'h43, 1'b0, 8'h64, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Start held 30 cycles: accepted every WIDTH+2 cycles
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (i % 10 == 0) begin
                e.sum = 8'h30; e.cout = 1'b0; e.cyc = cyc + int'(WIDTH);
                sb.push_back(e);
            end
        end
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in RUN cycle 4
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum",  32'(sum),  32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_fa",   32'({fa_x, fa_y, fa_z}), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        wait_idle();

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
